// File: rtl/decode_issue.sv
// Decode/issue stage: decodes a 16-bit instruction into a one-hot ALU control
// word, reads operands from an 8x16 register file with write-through bypass,
// and stalls on RAW hazards tracked by a per-register pending scoreboard.
// The issue bundle is registered and held while execute back-pressures.
module decode_issue #(
    parameter int XLEN = 16,
    parameter int NREG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [11:0]              alusignals,
    output logic [XLEN-1:0]          op1,
    output logic [XLEN-1:0]          op2,
    output logic [4:0]               immx,
    output logic                     isimmediate,
    output logic [$clog2(NREG)-1:0]  rd,
    output logic [XLEN-1:0]          stdata,
    input  logic                     wb_en,
    input  logic [$clog2(NREG)-1:0]  wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     illegal
);

    localparam int AW = $clog2(NREG);

    localparam logic [3:0] OP_ST  = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd9;

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    logic [3:0]      opc;
    logic            ibit;
    logic [AW-1:0]   f_rd;
    logic [AW-1:0]   f_rs1;
    logic [AW-1:0]   f_rs2;
    logic [4:0]      f_imm;

    assign opc   = in_instr[15:12];
    assign ibit  = in_instr[11];
    assign f_rd  = in_instr[10:8];
    assign f_rs1 = in_instr[7:5];
    assign f_rs2 = in_instr[4:2];
    assign f_imm = in_instr[4:0];

    logic is_alu, is_illegal, is_writer;
    logic use_rs1, use_rs2, use_rd;

    assign is_alu     = (opc <= 4'd11);
    assign is_illegal = (opc >= 4'd12) && (opc <= 4'd14);
    assign is_writer  = is_alu && (opc != OP_ST) && (opc != OP_CMP);
    assign use_rs1    = is_alu && (opc != OP_MOV);
    assign use_rs2    = is_alu && !ibit && (opc != OP_NOT);
    assign use_rd     = (opc == OP_ST);

    // A write-back landing this cycle both forwards its data and resolves the hazard.
    logic [XLEN-1:0] val_rs1, val_rs2, val_rd;
    assign val_rs1 = (wb_en && wb_addr == f_rs1) ? wb_data : rf[f_rs1];
    assign val_rs2 = (wb_en && wb_addr == f_rs2) ? wb_data : rf[f_rs2];
    assign val_rd  = (wb_en && wb_addr == f_rd)  ? wb_data : rf[f_rd];

    logic haz_rs1, haz_rs2, haz_rd, hazard, accept;
    assign haz_rs1 = use_rs1 && pending[f_rs1] && !(wb_en && wb_addr == f_rs1);
    assign haz_rs2 = use_rs2 && pending[f_rs2] && !(wb_en && wb_addr == f_rs2);
    assign haz_rd  = use_rd  && pending[f_rd]  && !(wb_en && wb_addr == f_rd);
    assign hazard  = haz_rs1 || haz_rs2 || haz_rd;

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Scoreboard next state: clear on write-back, then set on issue so set wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (accept && is_writer) begin
            pending_nxt[f_rd] = 1'b1;
        end
    end

    // Register file write port; reset clears every entry and masks write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Issue bundle: load on accepted ALU op, hold under back-pressure, zero when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            alusignals  <= '0;
            op1         <= '0;
            op2         <= '0;
            immx        <= '0;
            isimmediate <= 1'b0;
            rd          <= '0;
            stdata      <= '0;
            illegal     <= 1'b0;
        end else if (accept && is_alu) begin
            out_valid   <= 1'b1;
            alusignals  <= 12'd1 << opc;
            op1         <= use_rs1 ? val_rs1 : '0;
            op2         <= use_rs2 ? val_rs2 : '0;
            immx        <= ibit ? f_imm : 5'd0;
            isimmediate <= ibit;
            rd          <= f_rd;
            stdata      <= use_rd ? val_rd : '0;
        end else if (accept || out_ready) begin
            out_valid   <= 1'b0;
            alusignals  <= '0;
            op1         <= '0;
            op2         <= '0;
            immx        <= '0;
            isimmediate <= 1'b0;
            rd          <= '0;
            stdata      <= '0;
            if (accept && is_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios followed by random traffic, with
// a behavioural model predicting in_ready and pushing expected bundles into a
// queue that an independent monitor drains as the DUT presents them.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] alusignals;
    logic [15:0] op1, op2, stdata, wb_data;
    logic [4:0]  immx;
    logic        isimmediate;
    logic [2:0]  rd, wb_addr;
    logic        wb_en;
    logic        illegal;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .alusignals(alusignals), .op1(op1), .op2(op2), .immx(immx),
        .isimmediate(isimmediate), .rd(rd), .stdata(stdata),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal)
    );

    typedef struct packed {
        logic [11:0] alu;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  imm;
        logic        isimm;
        logic [2:0]  dst;
        logic [15:0] sd;
    } bundle_t;

    bundle_t     exq[$];
    int          total = 0;
    int          bad = 0;
    bit          checking = 0;

    logic [15:0] m_rf [8];
    bit          m_pend [8];
    bit          m_illegal = 0;

    bit          c_push, c_set, c_ill;
    logic [2:0]  c_setaddr;
    bundle_t     c_b;
    bit          hs;

    function automatic void check(string nm, logic [79:0] act, logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic logic [15:0] mread(logic [2:0] a);
        return (wb_en && wb_addr == a) ? wb_data : m_rf[a];
    endfunction

    // Model: decide acceptance from the instruction's source list and scoreboard.
    always @(negedge clk) begin
        logic [3:0] opc;
        logic [2:0] srcs[$];
        bit         haz, exp_rdy;
        bundle_t    b;
        opc  = in_instr[15:12];
        srcs = {};
        if (opc <= 11 && opc != 6) srcs.push_back(in_instr[7:5]);
        if (opc <= 11 && !in_instr[11] && opc != 9) srcs.push_back(in_instr[4:2]);
        if (opc == 2) srcs.push_back(in_instr[10:8]);
        haz = 0;
        foreach (srcs[k]) if (m_pend[srcs[k]] && !(wb_en && wb_addr == srcs[k])) haz = 1;
        exp_rdy = (exq.size() == 0 || out_ready) && !haz;
        c_push = 0; c_set = 0; c_ill = 0; c_setaddr = in_instr[10:8];
        if (checking && !rst) check("in_ready", in_ready, exp_rdy);
        if (in_valid && exp_rdy && !rst) begin
            if (opc <= 11) begin
                b.alu   = 12'd1 << opc;
                b.a     = (opc != 6) ? mread(in_instr[7:5]) : 16'h0;
                b.b     = (!in_instr[11] && opc != 9) ? mread(in_instr[4:2]) : 16'h0;
                b.imm   = in_instr[11] ? in_instr[4:0] : 5'h0;
                b.isimm = in_instr[11];
                b.dst   = in_instr[10:8];
                b.sd    = (opc == 2) ? mread(in_instr[10:8]) : 16'h0;
                c_b     = b;
                c_push  = 1;
                c_set   = !(opc == 2 || opc == 5);
            end else if (opc != 15) begin
                c_ill = 1;
            end
        end
    end

    // Model state commit at the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m_rf[i] = 16'h0; m_pend[i] = 0; end
            m_illegal = 0;
            exq.delete();
        end else begin
            if (wb_en) begin m_rf[wb_addr] = wb_data; m_pend[wb_addr] = 0; end
            if (c_set) m_pend[c_setaddr] = 1;
            if (c_push) exq.push_back(c_b);
            if (c_ill) m_illegal = 1;
        end
    end

    // Monitor: compare presented bundle with the oldest expectation.
    always @(negedge clk) begin
        hs = out_valid && out_ready && (exq.size() != 0);
        if (checking) begin
            check("out_valid", out_valid, exq.size() != 0);
            check("illegal", illegal, m_illegal);
            if (out_valid && exq.size() != 0)
                check("bundle", {alusignals, op1, op2, immx, isimmediate, rd, stdata}, exq[0]);
        end
    end

    always @(posedge clk) begin
        if (hs && !rst) void'(exq.pop_front());
    end

    task automatic drive(bit v, logic [15:0] ins, bit ordy, bit we, logic [2:0] wa, logic [15:0] wd);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] I_ADD3  = {4'd0, 1'b0, 3'd3, 3'd1, 3'd2, 2'b00};
    localparam logic [15:0] I_SUB4  = {4'd3, 1'b1, 3'd4, 3'd3, 5'd7};
    localparam logic [15:0] I_MOV5  = {4'd6, 1'b1, 3'd5, 3'd0, 5'd2};
    localparam logic [15:0] I_ADD6  = {4'd0, 1'b0, 3'd6, 3'd1, 3'd2, 2'b00};
    localparam logic [15:0] I_ST6   = {4'd2, 1'b1, 3'd6, 3'd1, 5'd4};
    localparam logic [15:0] I_OR7   = {4'd7, 1'b0, 3'd7, 3'd6, 3'd6, 2'b00};
    localparam logic [15:0] I_ADD2  = {4'd0, 1'b0, 3'd2, 3'd1, 3'd1, 2'b00};
    localparam logic [15:0] I_OR4   = {4'd7, 1'b0, 3'd4, 3'd2, 3'd3, 2'b00};

    initial begin
        rst = 1;
        drive(0, 16'h0, 1, 0, 0, 16'h0);
        step(); step();
        rst = 0;
        checking = 1;
        check("rst_out_valid", out_valid, 0);
        check("rst_illegal", illegal, 0);

        drive(0, 16'h0, 1, 1, 3'd1, 16'h0005); step();
        drive(0, 16'h0, 1, 1, 3'd2, 16'h0003); step();
        drive(1, I_ADD3, 1, 0, 0, 16'h0); step();
        check("add_valid", out_valid, 1);
        check("add_alu", alusignals, 12'h001);
        check("add_op1", op1, 16'h0005);
        check("add_op2", op2, 16'h0003);
        check("add_rd", rd, 3'd3);
        check("add_isimm", isimmediate, 0);

        drive(1, I_SUB4, 1, 0, 0, 16'h0); #1;
        check("sub_stall0", in_ready, 0);
        step();
        check("sub_stall1", in_ready, 0);
        drive(1, I_SUB4, 1, 1, 3'd3, 16'h0008); #1;
        check("sub_go", in_ready, 1);
        step();
        check("sub_alu", alusignals, 12'h008);
        check("sub_op1", op1, 16'h0008);
        check("sub_immx", immx, 5'd7);
        check("sub_isimm", isimmediate, 1);

        drive(1, I_MOV5, 0, 0, 0, 16'h0); #1;
        check("mov_blocked", in_ready, 0);
        step();
        check("hold_alu", alusignals, 12'h008);
        check("hold_valid", out_valid, 1);
        drive(1, I_MOV5, 1, 0, 0, 16'h0); #1;
        check("mov_ready", in_ready, 1);
        step();
        check("mov_alu", alusignals, 12'h040);
        check("mov_immx", immx, 5'd2);

        drive(1, {4'd13, 12'h0}, 1, 0, 0, 16'h0); step();
        drive(1, 16'hF000, 1, 0, 0, 16'h0); step();
        check("nop_ill_valid", out_valid, 0);
        check("ill_sticky", illegal, 1);

        drive(1, I_ADD6, 1, 0, 0, 16'h0); step();
        drive(1, I_ST6, 1, 0, 0, 16'h0); #1;
        check("st_stall", in_ready, 0);
        step();
        drive(1, I_ST6, 1, 1, 3'd6, 16'h1234); #1;
        check("st_go", in_ready, 1);
        step();
        check("st_alu", alusignals, 12'h004);
        check("st_op1", op1, 16'h0005);
        check("st_immx", immx, 5'd4);
        check("st_data", stdata, 16'h1234);
        drive(1, I_OR7, 1, 0, 0, 16'h0); #1;
        check("st_no_pending", in_ready, 1);
        step();
        check("ill_still", illegal, 1);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ins;
            bit          we;
            logic [2:0]  wa;
            logic [2:0]  p[$];
            p = {};
            for (int r = 0; r < 8; r++) if (m_pend[r]) p.push_back(3'(r));
            ins = 16'($urandom);
            if ($urandom_range(0, 15) != 0 && ins[15:12] inside {4'd12, 4'd13, 4'd14})
                ins[15:12] = 4'($urandom_range(0, 11));
            we = 0;
            wa = 3'($urandom);
            if (p.size() > 0 && $urandom_range(0, 2) != 0) begin
                we = 1;
                wa = p[$urandom_range(0, p.size() - 1)];
            end else if ($urandom_range(0, 4) == 0) begin
                we = 1;
            end
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 4) != 0, ins, $urandom_range(0, 3) != 0, we, wa, 16'($urandom));
            step();
        end
        rst = 0;

        rst = 1;
        drive(0, 16'h0, 1, 0, 0, 16'h0); step();
        rst = 0;
        drive(0, 16'h0, 1, 1, 3'd1, 16'h0007); step();
        drive(1, 16'hC000, 1, 0, 0, 16'h0); step();
        drive(1, I_ADD2, 0, 0, 0, 16'h0); step();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_illegal", illegal, 1);
        rst = 1;
        drive(1, I_OR4, 0, 1, 3'd3, 16'hBEEF); step();
        rst = 0;
        check("rst2_valid", out_valid, 0);
        check("rst2_illegal", illegal, 0);
        check("rst2_alu", alusignals, 12'h000);
        check("rst2_op1", op1, 16'h0);
        drive(1, I_OR4, 1, 0, 0, 16'h0); #1;
        check("rst2_no_stall", in_ready, 1);
        step();
        check("rst2_rd_op1", op1, 16'h0);
        check("rst2_rd_op2", op2, 16'h0);
        check("rst2_issue", out_valid, 1);
        drive(0, 16'h0, 1, 0, 0, 16'h0); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage feeding the execute-stage ALU.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and decodes the opcode into the ALU's 12-bit one-hot control word.
- Reads operands from an internal 8x16 register file and tracks pending writes with a scoreboard, stalling on RAW hazards.
- Presents a registered operand/control bundle to execute (op1, op2, immx, isimmediate, alusignals); write-back returns results to the register file.

Parameters:
- XLEN, 16, datapath and register width
- NREG, 8, architectural registers (3-bit specifiers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_instr  in  16  instruction word
- in_ready  out  1  stage accepts in_instr this cycle
- out_valid  out  1  issue bundle valid
- out_ready  in  1  execute accepts bundle
- alusignals  out  12  one-hot: bit0 add, 1 ld, 2 st, 3 sub, 4 mul, 5 cmp, 6 mov, 7 or, 8 and, 9 not, 10 lsl, 11 lsr
- op1  out  16  value of rs1
- op2  out  16  value of rs2 (R-form), else 0
- immx  out  5  instr[4:0] when I=1, else 0
- isimmediate  out  1  I bit
- rd  out  3  destination specifier
- stdata  out  16  value of rd register (st only, else 0)
- wb_en  in  1  write-back strobe
- wb_addr  in  3  write-back register
- wb_data  in  16  write-back value
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Instruction format: [15:12] opcode, [11] I, [10:8] rd, [7:5] rs1, [4:2] rs2 (R-form, I=0), [4:0] imm5 (I=1).
- Opcodes 0-11 map to alusignals bit of the same index. 15 = nop. 12-14 = illegal.
- Sources read: rs1 always, except mov. rs2 when I=0, except not. Register rd additionally for st.
- Writers are all opcodes 0-11 except st and cmp.
- Register file: 8x16, write on wb_en. A read of wb_addr in the same cycle returns wb_data (write-through bypass).
- Scoreboard: 8 pending bits.
  - Set for rd when a writer is accepted (in_valid && in_ready).
  - Cleared for wb_addr on wb_en.
  - Set and clear on the same register in the same cycle: set wins.
- Hazard: any read source has its pending bit set and is not being cleared this cycle by wb_en.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - On acceptance the bundle registers next edge (latency 1); out_valid=1 for opcodes 0-11.
  - Bundle holds stable while out_valid && !out_ready.
  - out_valid clears when out_ready=1 and no new instruction is accepted.
- nop and illegal: accepted and consumed (in_ready rules unchanged), produce no bundle; out_valid drops if the previous bundle drains.
- Illegal sets illegal=1, held until rst.
- Unused output fields are driven 0.
- Reset (any cycle, including mid-stall or with a bundle pending):
  - Next edge: out_valid=0, all outputs 0, illegal=0.
  - Scoreboard cleared, register file cleared to 0.
  - In-flight bundle discarded.
  - wb_en in the reset cycle is ignored.
- Back-to-back: with out_ready=1 and no hazards, one instruction issues per cycle.

Test Plan:
- Reset, then wb_en r1=0x0005, r2=0x0003; issue add r3,r1,r2 (R) with out_ready=1 -> next cycle out_valid=1, alusignals=0x001, op1=0x0005, op2=0x0003, rd=3, isimmediate=0.
- Issue sub r4,r3,#7 (I=1) directly after add r3 -> in_ready=0 until wb_en r3=0x0008. In that same cycle in_ready=1, and the bundle shows alusignals=0x008, op1=0x0008, immx=7, isimmediate=1.
- Hold out_ready=0 with a bundle pending and present mov r5,#2 -> in_ready=0 and bundle unchanged. Raise out_ready -> mov bundle next cycle, alusignals=0x040.
- Present opcode 13, then nop -> both consumed, no out_valid, illegal=1 and remains 1 until rst.
- st r6,[r1,#4] with r6 pending -> stall. After wb r6=0x1234: alusignals=0x004, op1=r1, immx=4, stdata=0x1234, and no scoreboard set for r6.
- Assert rst while a bundle is pending and the scoreboard is non-empty -> next edge out_valid=0, illegal=0. A read of any register returns 0 and no stall occurs.
